// File: rtl/stitch_vfpr_mp.sv
// Multi-port operand collector: issues per-port reads, gathers out-of-order
// responses into per-port FIFOs and hands complete operand sets back in order.
module stitch_vfpr_mp #(
  parameter int DataWidth = 64,
  parameter int AddrWidth = 8,
  parameter int NumRead   = 3,
  parameter int Depth     = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               rreq_valid_i,
  output logic                               rreq_ready_o,
  input  logic [NumRead*AddrWidth-1:0]       raddr_i,
  input  logic [NumRead-1:0]                 rmask_i,
  input  logic [AddrWidth-1:0]               waddr_i,
  input  logic [DataWidth-1:0]               wdata_i,
  input  logic                               wvalid_i,
  output logic                               wready_o,
  output logic [NumRead*DataWidth-1:0]       rdata_o,
  output logic                               rdata_valid_o,
  input  logic                               rdata_ready_i,
  output logic [NumRead:0]                   mem_q_valid_o,
  input  logic [NumRead:0]                   mem_q_ready_i,
  output logic [(NumRead+1)*AddrWidth-1:0]   mem_q_addr_o,
  output logic [NumRead:0]                   mem_q_write_o,
  output logic [DataWidth-1:0]               mem_q_wdata_o,
  input  logic [NumRead-1:0]                 mem_p_valid_i,
  input  logic [NumRead*DataWidth-1:0]       mem_p_data_i
);
  localparam int PtrW = $clog2(Depth);
  localparam int CntW = $clog2(Depth + 1);

  typedef logic [PtrW:0]   ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  logic [NumRead-1:0]           iss_pend_q, iss_pend_d;
  logic [NumRead*AddrWidth-1:0] iss_addr_q, iss_addr_d;
  ptr_t                         trk_wptr_q, trk_wptr_d, trk_rptr_q, trk_rptr_d;
  ptr_t                         res_wptr_q [NumRead];
  ptr_t                         res_wptr_d [NumRead];
  ptr_t                         res_rptr_q [NumRead];
  ptr_t                         res_rptr_d [NumRead];
  cnt_t                         out_q [NumRead];
  cnt_t                         out_d [NumRead];
  logic [NumRead-1:0]           trk_mem_q [Depth];
  logic [DataWidth-1:0]         res_mem_q [NumRead][Depth];

  logic [NumRead-1:0] grant, head_mask, res_empty, res_push, res_pop;
  logic               trk_empty, trk_full, issue_done, deliver, accept;

  always_comb begin
    grant      = iss_pend_q & mem_q_ready_i[NumRead-1:0];
    issue_done = (iss_pend_q & ~grant) == '0;
    trk_empty  = trk_wptr_q == trk_rptr_q;
    trk_full   = (trk_wptr_q[PtrW] != trk_rptr_q[PtrW]) &&
                 (trk_wptr_q[PtrW-1:0] == trk_rptr_q[PtrW-1:0]);
    head_mask  = trk_mem_q[trk_rptr_q[PtrW-1:0]];
    rdata_valid_o = !trk_empty;
    for (int p = 0; p < NumRead; p++) begin
      res_empty[p] = res_wptr_q[p] == res_rptr_q[p];
      if (head_mask[p] && res_empty[p]) rdata_valid_o = 1'b0;
    end
  end

  // A pop on a full tracker frees the slot for a same-cycle accept.
  always_comb begin
    deliver      = rdata_valid_o && rdata_ready_i;
    rreq_ready_o = !rst_i && issue_done && (!trk_full || deliver);
    accept       = rreq_valid_i && rreq_ready_o;
    for (int p = 0; p < NumRead; p++) begin
      res_push[p] = mem_p_valid_i[p] && (out_q[p] != '0);
      res_pop[p]  = deliver && head_mask[p];
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    iss_pend_d = iss_pend_q & ~grant;
    iss_addr_d = iss_addr_q;
    trk_wptr_d = trk_wptr_q + ptr_t'(accept);
    trk_rptr_d = trk_rptr_q + ptr_t'(deliver);
    if (accept) begin
      iss_pend_d = rmask_i;
      iss_addr_d = raddr_i;
    end
    for (int p = 0; p < NumRead; p++) begin
      res_wptr_d[p] = res_wptr_q[p] + ptr_t'(res_push[p]);
      res_rptr_d[p] = res_rptr_q[p] + ptr_t'(res_pop[p]);
      out_d[p]      = out_q[p] + cnt_t'(grant[p]) - cnt_t'(res_push[p]);
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int p = 0; p < NumRead; p++) begin
      if (!trk_empty && head_mask[p])
        rdata_o[p*DataWidth +: DataWidth] = res_mem_q[p][res_rptr_q[p][PtrW-1:0]];
    end
  end

  assign mem_q_valid_o = {wvalid_i & ~rst_i, iss_pend_q};
  assign mem_q_addr_o  = {waddr_i, iss_addr_q};
  assign mem_q_write_o = {1'b1, {NumRead{1'b0}}};
  assign mem_q_wdata_o = wdata_i;
  assign wready_o      = mem_q_ready_i[NumRead];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      iss_pend_q <= '0;
      iss_addr_q <= '0;
      trk_wptr_q <= '0;
      trk_rptr_q <= '0;
      for (int p = 0; p < NumRead; p++) begin
        res_wptr_q[p] <= '0;
        res_rptr_q[p] <= '0;
        out_q[p]      <= '0;
      end
    end else begin
      iss_pend_q <= iss_pend_d;
      iss_addr_q <= iss_addr_d;
      trk_wptr_q <= trk_wptr_d;
      trk_rptr_q <= trk_rptr_d;
      for (int p = 0; p < NumRead; p++) begin
        res_wptr_q[p] <= res_wptr_d[p];
        res_rptr_q[p] <= res_rptr_d[p];
        out_q[p]      <= out_d[p];
      end
    end
  end

  // NOTE: storage arrays carry no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (accept) trk_mem_q[trk_wptr_q[PtrW-1:0]] <= rmask_i;
    for (int p = 0; p < NumRead; p++) begin
      if (res_push[p])
        res_mem_q[p][res_wptr_q[p][PtrW-1:0]] <= mem_p_data_i[p*DataWidth +: DataWidth];
    end
  end

  // A response on a port with nothing outstanding is dropped above.
  for (genvar p = 0; p < NumRead; p++) begin : g_resp_chk
    a_no_orphan_resp: assert property (@(posedge clk_i) disable iff (rst_i)
      mem_p_valid_i[p] |-> out_q[p] != '0);
  end
endmodule

// File: tb/tb_stitch_vfpr_mp.sv
// Directed bench for stitch_vfpr_mp: a latency-programmable memory model
// answers reads, and delivered operand sets are compared against expected sets.
module tb_stitch_vfpr_mp;
  localparam int DW = 64;
  localparam int AW = 8;
  localparam int NR = 3;
  localparam int D  = 4;

  logic                  clk_i = 1'b0;
  logic                  rst_i = 1'b1;
  logic                  rreq_valid_i = 1'b0;
  logic                  rreq_ready_o;
  logic [NR*AW-1:0]      raddr_i = '0;
  logic [NR-1:0]         rmask_i = '0;
  logic [AW-1:0]         waddr_i = '0;
  logic [DW-1:0]         wdata_i = '0;
  logic                  wvalid_i = 1'b1;
  logic                  wready_o;
  logic [NR*DW-1:0]      rdata_o;
  logic                  rdata_valid_o;
  logic                  rdata_ready_i = 1'b0;
  logic [NR:0]           mem_q_valid_o;
  logic [NR:0]           mem_q_ready_i = '1;
  logic [(NR+1)*AW-1:0]  mem_q_addr_o;
  logic [NR:0]           mem_q_write_o;
  logic [DW-1:0]         mem_q_wdata_o;
  logic [NR-1:0]         mem_p_valid_i = '0;
  logic [NR*DW-1:0]      mem_p_data_i = '0;

  stitch_vfpr_mp #(.DataWidth(DW), .AddrWidth(AW), .NumRead(NR), .Depth(D)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rreq_valid_i(rreq_valid_i), .rreq_ready_o(rreq_ready_o),
    .raddr_i(raddr_i), .rmask_i(rmask_i),
    .waddr_i(waddr_i), .wdata_i(wdata_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o), .rdata_ready_i(rdata_ready_i),
    .mem_q_valid_o(mem_q_valid_o), .mem_q_ready_i(mem_q_ready_i),
    .mem_q_addr_o(mem_q_addr_o), .mem_q_write_o(mem_q_write_o),
    .mem_q_wdata_o(mem_q_wdata_o),
    .mem_p_valid_i(mem_p_valid_i), .mem_p_data_i(mem_p_data_i)
  );

  always #5 clk_i = ~clk_i;

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [NR*AW-1:0] addr;
    logic [NR-1:0]    mask;
  } set_t;

  set_t exp_q[$];

  function automatic logic [DW-1:0] memv(input logic [AW-1:0] a);
    return {32'hC0DE_0000 | 32'(a), 32'h1234_5600 + 32'(a)};
  endfunction

  function automatic logic [NR*DW-1:0] expect_data(input set_t s);
    logic [NR*DW-1:0] r = '0;
    for (int p = 0; p < NR; p++)
      if (s.mask[p]) r[p*DW +: DW] = memv(s.addr[p*AW +: AW]);
    return r;
  endfunction

  function automatic logic [NR*AW-1:0] set_addr(input int n);
    logic [AW-1:0] b = 8'(8'h40 + 3 * n);
    return {b + 8'd2, b + 8'd1, b};
  endfunction

  // Memory model: each granted read answers lat[p] cycles later, in order per port.
  int unsigned   lat [NR];
  int unsigned   due_q [NR][$];
  logic [AW-1:0] adr_q [NR][$];

  always @(negedge clk_i) begin
    if (!rst_i)
      for (int p = 0; p < NR; p++)
        if (mem_q_valid_o[p] && mem_q_ready_i[p]) begin
          due_q[p].push_back(cyc + lat[p]);
          adr_q[p].push_back(mem_q_addr_o[p*AW +: AW]);
        end
  end

  always @(posedge clk_i) begin
    #1;
    for (int p = 0; p < NR; p++) begin
      mem_p_valid_i[p]          = 1'b0;
      mem_p_data_i[p*DW +: DW]  = '0;
      if (rst_i) begin
        due_q[p].delete();
        adr_q[p].delete();
      end else if (due_q[p].size() > 0 && due_q[p][0] <= cyc) begin
        mem_p_valid_i[p]         = 1'b1;
        mem_p_data_i[p*DW +: DW] = memv(adr_q[p][0]);
        void'(due_q[p].pop_front());
        void'(adr_q[p].pop_front());
      end
    end
  end

  bit watch02 = 1'b0;
  int viol02  = 0;
  always @(negedge clk_i)
    if (watch02 && (mem_q_valid_o[0] || mem_q_valid_o[2])) viol02++;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_lat(input int unsigned l0, input int unsigned l1, input int unsigned l2);
    lat[0] = l0;
    lat[1] = l1;
    lat[2] = l2;
  endtask

  // Offers one set until accepted; acc is the cycle in which the handshake held.
  task automatic send(input string tag, input logic [NR*AW-1:0] addr,
                      input logic [NR-1:0] mask, output int unsigned acc);
    bit ok = 1'b0;
    acc          = 0;
    rreq_valid_i = 1'b1;
    raddr_i      = addr;
    rmask_i      = mask;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk_i);
      ok  = rreq_ready_o;
      acc = cyc;
      tick();
    end
    rreq_valid_i = 1'b0;
    check({tag, "_accept"}, 192'(ok), 192'(1'b1));
    exp_q.push_back('{addr: addr, mask: mask});
  endtask

  // Waits for the next set, compares it with the oldest expected set, pops it.
  task automatic drain_one(input string tag, output int unsigned at);
    bit   ok = 1'b0;
    set_t s;
    at = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk_i);
      ok = rdata_valid_o;
      if (!ok) tick();
    end
    check({tag, "_valid"}, 192'(ok), 192'(1'b1));
    if (ok) begin
      at = cyc;
      s  = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check({tag, "_data"}, 192'(rdata_o), 192'(expect_data(s)));
      rdata_ready_i = 1'b1;
      tick();
      rdata_ready_i = 1'b0;
    end
  endtask

  initial begin
    int unsigned acc, acc2, at, at2;
    int          n, bad;
    set_lat(1, 1, 1);

    // Reset state, with a write offered to confirm the write lane is held low.
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_rreq_ready",  192'(rreq_ready_o),  192'(1'b0));
    check("rst_rdata_valid", 192'(rdata_valid_o), 192'(1'b0));
    check("rst_mem_q_valid", 192'(mem_q_valid_o), 192'(4'b0000));
    check("rst_rdata",       192'(rdata_o),       192'(0));
    tick();
    rst_i    = 1'b0;
    wvalid_i = 1'b0;
    @(negedge clk_i);
    check("post_rst_ready", 192'(rreq_ready_o), 192'(1'b1));
    tick();

    // Write pass-through.
    wvalid_i         = 1'b1;
    waddr_i          = 8'h4C;
    wdata_i          = 64'hDEAD_BEEF_0123_4567;
    mem_q_ready_i[3] = 1'b0;
    #1;
    check("wr_valid",    192'(mem_q_valid_o),            192'(4'b1000));
    check("wr_addr",     192'(mem_q_addr_o[3*AW +: AW]), 192'(8'h4C));
    check("wr_flag",     192'(mem_q_write_o),            192'(4'b1000));
    check("wr_data",     192'(mem_q_wdata_o),            192'(64'hDEAD_BEEF_0123_4567));
    check("wr_ready_lo", 192'(wready_o),                 192'(1'b0));
    mem_q_ready_i[3] = 1'b1;
    #1;
    check("wr_ready_hi", 192'(wready_o), 192'(1'b1));
    wvalid_i = 1'b0;
    tick();

    // Single full set, minimum latency.
    send("r19", {8'd3, 8'd2, 8'd1}, 3'b111, acc);
    @(negedge clk_i);
    check("r19_q_valid", 192'(mem_q_valid_o[NR-1:0]), 192'(3'b111));
    check("r19_q_addr",  192'(mem_q_addr_o[NR*AW-1:0]), 192'(24'h03_02_01));
    tick();
    drain_one("r19", at);
    check("r19_latency", 192'(at - acc), 192'(3));

    // Port 2 answers five cycles after ports 0/1.
    set_lat(1, 1, 6);
    send("r20", {8'h23, 8'h22, 8'h21}, 3'b111, acc);
    drain_one("r20", at);
    check("r20_latency", 192'(at - acc), 192'(8));
    set_lat(1, 1, 1);

    // Tracker fills at Depth sets; a pop admits the fifth in the same cycle.
    n            = 0;
    rmask_i      = 3'b111;
    for (int i = 0; i < 12; i++) begin
      rreq_valid_i = (n < 5);
      raddr_i      = set_addr(n);
      @(negedge clk_i);
      if (rreq_valid_i && rreq_ready_o) begin
        exp_q.push_back('{addr: set_addr(n), mask: 3'b111});
        n++;
      end
      tick();
    end
    check("r21_accepted", 192'(n), 192'(4));
    @(negedge clk_i);
    check("r21_full_ready", 192'(rreq_ready_o),  192'(1'b0));
    check("r21_head_valid", 192'(rdata_valid_o), 192'(1'b1));
    check("r21_head_data",  192'(rdata_o),       192'(expect_data(exp_q[0])));
    rdata_ready_i = 1'b1;
    #1;
    check("r21_ready_on_pop", 192'(rreq_ready_o), 192'(1'b1));
    tick();
    rreq_valid_i  = 1'b0;
    rdata_ready_i = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back('{addr: set_addr(4), mask: 3'b111});
    for (int k = 0; k < 4; k++) drain_one("r21_drain", at);

    // Partial mask then empty mask: no traffic on ports 0/2, delivered in order.
    watch02 = 1'b1;
    viol02  = 0;
    send("r22a", {8'h59, 8'h58, 8'h57}, 3'b010, acc);
    send("r22b", {8'h69, 8'h68, 8'h67}, 3'b000, acc2);
    drain_one("r22a", at);
    drain_one("r22b", at2);
    watch02 = 1'b0;
    check("r22_no_port02_traffic", 192'(viol02), 192'(0));
    check("r22_order", 192'(at2 > at), 192'(1'b1));

    // Port 1 stalled by memory for 10 cycles.
    mem_q_ready_i[1] = 1'b0;
    send("r23", {8'h33, 8'h22, 8'h11}, 3'b111, acc);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (!mem_q_valid_o[1] || mem_q_addr_o[AW +: AW] != 8'h22 || rreq_ready_o) bad++;
      tick();
    end
    check("r23_stall_hold", 192'(bad), 192'(0));
    mem_q_ready_i[1] = 1'b1;
    drain_one("r23", at);
    @(negedge clk_i);
    check("r23_ready_back", 192'(rreq_ready_o), 192'(1'b1));
    tick();

    // Reset with two sets in flight.
    set_lat(8, 8, 8);
    send("r24a", {8'h73, 8'h72, 8'h71}, 3'b111, acc);
    send("r24b", {8'h83, 8'h82, 8'h81}, 3'b111, acc2);
    tick();
    rst_i    = 1'b1;
    wvalid_i = 1'b1;
    #1;
    check("r24_rst_ready",   192'(rreq_ready_o),  192'(1'b0));
    check("r24_rst_valid",   192'(rdata_valid_o), 192'(1'b0));
    check("r24_rst_q_valid", 192'(mem_q_valid_o), 192'(4'b0000));
    check("r24_rst_rdata",   192'(rdata_o),       192'(0));
    tick();
    tick();
    rst_i    = 1'b0;
    wvalid_i = 1'b0;
    exp_q.delete();
    set_lat(1, 1, 1);
    @(negedge clk_i);
    check("r24_ready_after_rst", 192'(rreq_ready_o), 192'(1'b1));
    tick();
    send("r24_fresh", {8'h93, 8'h92, 8'h91}, 3'b101, acc);
    drain_one("r24_fresh", at);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      if (rdata_valid_o) bad++;
      tick();
    end
    check("r24_no_stale", 192'(bad), 192'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
